// File: rtl/pma_arb_gen_if.sv
// Bus bundle for pma_arb_gen: requestor inputs, sweep/ERA controls and the granted address outputs.
// The master side drives requests; the slave side is the address generator.
interface pma_arb_gen_if #(
    parameter int unsigned PA_W  = 22,
    parameter int unsigned OFF_W = 9,
    parameter int unsigned NREQ  = 4
);
    localparam int unsigned PG_W = PA_W - OFF_W;

    logic [NREQ-1:0]      req;
    logic [NREQ*PA_W-1:0] req_adr;
    logic [NREQ*2-1:0]    req_kind;
    logic                 cyc_done;
    logic                 ubr_ld;
    logic                 ebr_ld;
    logic [PG_W-1:0]      base_d;
    logic                 sweep_start;
    logic                 sweep_all;
    logic [PG_W-1:0]      sweep_page;
    logic                 err_in;
    logic                 era_unlock;

    logic [NREQ:0]        grant;
    logic                 pa_valid;
    logic [PA_W-1:0]      pa;
    logic                 pa_par;
    logic                 busy;
    logic                 sweep_busy;
    logic                 sweep_done;
    logic [PA_W-1:0]      era;
    logic                 era_held;

    modport master (
        output req, req_adr, req_kind, cyc_done, ubr_ld, ebr_ld, base_d,
               sweep_start, sweep_all, sweep_page, err_in, era_unlock,
        input  grant, pa_valid, pa, pa_par, busy, sweep_busy, sweep_done, era, era_held
    );

    modport slave (
        input  req, req_adr, req_kind, cyc_done, ubr_ld, ebr_ld, base_d,
               sweep_start, sweep_all, sweep_page, err_in, era_unlock,
        output grant, pa_valid, pa, pa_par, busy, sweep_busy, sweep_done, era, era_held
    );
endinterface

// File: rtl/pma_arb_gen.sv
// Physical-address generator: fixed-priority arbitration over NREQ requestors plus a cache-sweep
// engine, base-register relocation, parity and a freezable error-address register.
module pma_arb_gen #(
    parameter int unsigned PA_W    = 22,
    parameter int unsigned OFF_W   = 9,
    parameter int unsigned LINE_W  = 7,
    parameter int unsigned NREQ    = 4,
    parameter bit          PAR_ODD = 1'b1
) (
    input logic           clock,
    input logic           reset_n,
    pma_arb_gen_if.slave  bus
);
    localparam int unsigned PG_W = PA_W - OFF_W;

    typedef enum logic [0:0] {StIdle, StCyc} state_e;

    state_e            state_q;
    logic [NREQ:0]     grant_q;
    logic              pa_valid_q;
    logic [PA_W-1:0]   pa_q;
    logic              pa_par_q;
    logic              sweep_busy_q;
    logic              sweep_last_q;
    logic              sweep_done_q;
    logic              sweep_all_q;
    logic [PG_W-1:0]   spage_q;
    logic [LINE_W-1:0] sline_q;
    logic [PA_W-1:0]   era_q;
    logic              era_held_q;
    logic [PG_W-1:0]   ubr_q;
    logic [PG_W-1:0]   ebr_q;

    logic              arb;
    logic              err_cyc;
    logic              sweep_end;
    logic [NREQ:0]     win;
    logic [PA_W-1:0]   win_pa;
    logic [OFF_W-1:0]  sw_off;

    function automatic logic [PA_W-1:0] reloc(input logic [PA_W-1:0] adr,
                                              input logic [1:0]      kind,
                                              input logic [PG_W-1:0] ubr,
                                              input logic [PG_W-1:0] ebr);
        logic [PA_W-1:0] res;
        unique case (kind)
            2'd0:    res = adr;
            2'd1:    res = {ubr, adr[OFF_W-1:0]};
            2'd2:    res = {ebr, adr[OFF_W-1:0]};
            default: res = adr[PA_W-1] ? {ubr, adr[OFF_W-1:0]} : {ebr, adr[OFF_W-1:0]};
        endcase
        return res;
    endfunction

    assign arb       = (state_q == StIdle) || bus.cyc_done;
    assign err_cyc   = (state_q == StCyc) && bus.err_in;
    assign sweep_end = (state_q == StCyc) && bus.cyc_done && grant_q[NREQ] && sweep_last_q;
    assign sw_off    = OFF_W'(sline_q) << (OFF_W - LINE_W);

    // Sweep is the default winner; the descending scan lets lower indices override it.
    always_comb begin
        win    = '0;
        win_pa = '0;
        if (sweep_busy_q && !sweep_last_q) begin
            win[NREQ] = 1'b1;
            win_pa    = {spage_q, sw_off};
        end
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (bus.req[i]) begin
                win    = '0;
                win[i] = 1'b1;
                win_pa = reloc(bus.req_adr[i*PA_W +: PA_W], bus.req_kind[2*i +: 2], ubr_q, ebr_q);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            grant_q      <= '0;
            pa_valid_q   <= 1'b0;
            pa_q         <= '0;
            pa_par_q     <= PAR_ODD;
            sweep_busy_q <= 1'b0;
            sweep_last_q <= 1'b0;
            sweep_done_q <= 1'b0;
            sweep_all_q  <= 1'b0;
            spage_q      <= '0;
            sline_q      <= '0;
            era_q        <= '0;
            era_held_q   <= 1'b0;
            ubr_q        <= '0;
            ebr_q        <= '0;
        end else begin
            pa_valid_q   <= 1'b0;
            sweep_done_q <= 1'b0;

            if (arb) begin
                if (|win) begin
                    state_q    <= StCyc;
                    grant_q    <= win;
                    pa_q       <= win_pa;
                    pa_par_q   <= (^win_pa) ^ PAR_ODD;
                    pa_valid_q <= 1'b1;
                    // An error on the closing cycle must keep that cycle's address.
                    if (!era_held_q && !err_cyc) begin
                        era_q <= win_pa;
                    end
                end else begin
                    state_q <= StIdle;
                    grant_q <= '0;
                end
            end

            if (arb && win[NREQ]) begin
                if (sline_q != '0) begin
                    sline_q <= sline_q - LINE_W'(1);
                end else if (sweep_all_q && spage_q != '0) begin
                    spage_q <= spage_q - PG_W'(1);
                    sline_q <= '1;
                end else begin
                    sweep_last_q <= 1'b1;
                end
            end else if (bus.sweep_start && !sweep_busy_q) begin
                spage_q      <= bus.sweep_page;
                sline_q      <= '1;
                sweep_all_q  <= bus.sweep_all;
                sweep_busy_q <= 1'b1;
                sweep_last_q <= 1'b0;
            end

            if (sweep_end) begin
                sweep_busy_q <= 1'b0;
                sweep_last_q <= 1'b0;
                sweep_done_q <= 1'b1;
            end

            if (err_cyc) begin
                era_held_q <= 1'b1;
            end else if (bus.era_unlock) begin
                era_held_q <= 1'b0;
            end

            if (bus.ubr_ld) begin
                ubr_q <= bus.base_d;
            end
            if (bus.ebr_ld) begin
                ebr_q <= bus.base_d;
            end
        end
    end

    assign bus.grant      = grant_q;
    assign bus.pa_valid   = pa_valid_q;
    assign bus.pa         = pa_q;
    assign bus.pa_par     = pa_par_q;
    assign bus.busy       = (state_q == StCyc);
    assign bus.sweep_busy = sweep_busy_q;
    assign bus.sweep_done = sweep_done_q;
    assign bus.era        = era_q;
    assign bus.era_held   = era_held_q;
endmodule

// File: tb/tb_pma_arb_gen.sv
// Self-checking bench for pma_arb_gen: directed table, multi-cycle sequences and random stimulus
// compared every cycle against a queue-based reference model.
module tb_pma_arb_gen;
    localparam int unsigned PA_W    = 22;
    localparam int unsigned OFF_W   = 9;
    localparam int unsigned LINE_W  = 7;
    localparam int unsigned NREQ    = 4;
    localparam bit          PAR_ODD = 1'b1;
    localparam int unsigned PG_W    = PA_W - OFF_W;

    logic clock;
    logic reset_n;
    int   nvec;
    int   nerr;

    pma_arb_gen_if #(.PA_W(PA_W), .OFF_W(OFF_W), .NREQ(NREQ)) bus ();

    pma_arb_gen #(
        .PA_W(PA_W), .OFF_W(OFF_W), .LINE_W(LINE_W), .NREQ(NREQ), .PAR_ODD(PAR_ODD)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model state
    int              m_gnt;
    logic            m_busy, m_pv, m_sb, m_sd, m_held, m_term;
    logic [PA_W-1:0] m_pa, m_era;
    logic [PG_W-1:0] m_ubr, m_ebr;
    logic [PA_W-1:0] sq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            if (nerr <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic exp_par(input logic [PA_W-1:0] a);
        int ones;
        ones = $countones(a);
        return PAR_ODD ? ((ones % 2) == 0) : ((ones % 2) == 1);
    endfunction

    function automatic logic [PA_W-1:0] page_addr(input int page, input int line);
        return PA_W'(page * (2 ** OFF_W) + line * (2 ** (OFF_W - LINE_W)));
    endfunction

    function automatic logic [PA_W-1:0] ref_addr(input int i);
        logic [PA_W-1:0] a;
        logic [1:0]      k;
        logic [PG_W-1:0] b;
        a = bus.req_adr[i*PA_W +: PA_W];
        k = bus.req_kind[2*i +: 2];
        if (k == 2'd0) return a;
        b = (k == 2'd1 || (k == 2'd3 && a[PA_W-1])) ? m_ubr : m_ebr;
        return PA_W'(int'(b) * (2 ** OFF_W) + int'(a) % (2 ** OFF_W));
    endfunction

    task automatic model_reset();
        m_gnt = -1; m_busy = 0; m_pv = 0; m_sb = 0; m_sd = 0; m_held = 0; m_term = 0;
        m_pa = '0; m_era = '0; m_ubr = '0; m_ebr = '0;
        sq.delete();
    endtask

    task automatic model_edge();
        int              w;
        logic            arb, err_now, term_done, sb_old;
        logic [PA_W-1:0] addr;
        w         = -1;
        sb_old    = m_sb;
        arb       = !m_busy || bus.cyc_done;
        err_now   = m_busy && bus.err_in;
        term_done = m_busy && bus.cyc_done && m_gnt == int'(NREQ) && m_term;
        m_pv = 0;
        m_sd = 0;
        if (term_done) begin
            m_sb = 0; m_sd = 1; m_term = 0;
        end
        if (arb) begin
            for (int i = 0; i < int'(NREQ); i++) if (w < 0 && bus.req[i]) w = i;
            if (w < 0 && sq.size() > 0) w = NREQ;
            if (w < 0) begin
                m_busy = 0; m_gnt = -1;
            end else begin
                if (w == int'(NREQ)) begin
                    addr = sq.pop_front();
                    if (sq.size() == 0) m_term = 1;
                end else begin
                    addr = ref_addr(w);
                end
                m_busy = 1; m_gnt = w; m_pa = addr; m_pv = 1;
                if (!m_held && !err_now) m_era = addr;
            end
        end
        if (!sb_old && bus.sweep_start) begin
            for (int p = int'(bus.sweep_page); p >= 0; p--) begin
                for (int l = 2 ** LINE_W - 1; l >= 0; l--) sq.push_back(page_addr(p, l));
                if (!bus.sweep_all) break;
            end
            m_sb = 1;
        end
        if (err_now) m_held = 1;
        else if (bus.era_unlock) m_held = 0;
        if (bus.ubr_ld) m_ubr = bus.base_d;
        if (bus.ebr_ld) m_ebr = bus.base_d;
    endtask

    task automatic check_all();
        logic [NREQ:0] g;
        g = '0;
        if (m_gnt >= 0) g[m_gnt] = 1'b1;
        chk("grant", 64'(bus.grant), 64'(g));
        chk("pa_valid", 64'(bus.pa_valid), 64'(m_pv));
        chk("pa", 64'(bus.pa), 64'(m_pa));
        chk("pa_par", 64'(bus.pa_par), 64'(exp_par(m_pa)));
        chk("busy", 64'(bus.busy), 64'(m_busy));
        chk("sweep_busy", 64'(bus.sweep_busy), 64'(m_sb));
        chk("sweep_done", 64'(bus.sweep_done), 64'(m_sd));
        chk("era", 64'(bus.era), 64'(m_era));
        chk("era_held", 64'(bus.era_held), 64'(m_held));
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle_inputs();
        bus.req = '0; bus.req_adr = '0; bus.req_kind = '0; bus.cyc_done = 0;
        bus.ubr_ld = 0; bus.ebr_ld = 0; bus.base_d = '0; bus.sweep_start = 0;
        bus.sweep_all = 0; bus.sweep_page = '0; bus.err_in = 0; bus.era_unlock = 0;
    endtask

    typedef struct {
        logic [NREQ-1:0] req;
        int              idx;
        logic [1:0]      kind;
        logic [PA_W-1:0] adr;
        logic [NREQ:0]   gnt;
        logic [PA_W-1:0] pa;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int              cnt, dcnt, ecnt;
        logic [PA_W-1:0] first_pa, last_pa;

        nvec = 0;
        nerr = 0;
        tbl[0] = '{4'b1010, 1, 2'd1 - 2'd1, 22'h012345, 5'b00010, 22'h012345};
        tbl[1] = '{4'b0001, 0, 2'd2, 22'h3FF123, 5'b00001, {13'h0A5, 9'h123}};
        tbl[2] = '{4'b0100, 2, 2'd1, 22'h000FFF, 5'b00100, {13'h1C3, 9'h1FF}};
        tbl[3] = '{4'b1000, 3, 2'd3, 22'h200055, 5'b01000, {13'h1C3, 9'h055}};
        tbl[4] = '{4'b1100, 2, 2'd3, 22'h100055, 5'b00100, {13'h0A5, 9'h055}};
        tbl[5] = '{4'b1111, 0, 2'd0, 22'h3FFFFF, 5'b00001, 22'h3FFFFF};

        idle_inputs();
        reset_n = 1'b0;
        model_reset();
        #12;
        check_all();
        chk("rst_pa_par", 64'(bus.pa_par), 64'(PAR_ODD));
        #10 reset_n = 1'b1;

        // Base registers for the relocation table
        bus.ebr_ld = 1; bus.base_d = 13'h0A5; tick();
        bus.ebr_ld = 0; bus.ubr_ld = 1; bus.base_d = 13'h1C3; tick();
        bus.ubr_ld = 0;

        foreach (tbl[v]) begin
            for (int j = 0; j < int'(NREQ); j++) begin
                bus.req_adr[j*PA_W +: PA_W] = 22'h3C0000 | PA_W'(j);
                bus.req_kind[2*j +: 2]      = 2'd0;
            end
            bus.req_adr[tbl[v].idx*PA_W +: PA_W] = tbl[v].adr;
            bus.req_kind[2*tbl[v].idx +: 2]      = tbl[v].kind;
            bus.req = tbl[v].req;
            tick();
            chk("tbl_grant", 64'(bus.grant), 64'(tbl[v].gnt));
            chk("tbl_pa", 64'(bus.pa), 64'(tbl[v].pa));
            chk("tbl_par", 64'(bus.pa_par), 64'(exp_par(tbl[v].pa)));
            bus.req = '0; bus.cyc_done = 1; tick();
            bus.cyc_done = 0;
        end

        // Back-to-back: lower index first, higher follows with no idle cycle
        bus.req = 4'b1010; tick();
        chk("b2b_first", 64'(bus.grant), 64'(5'b00010));
        bus.req = 4'b1000; bus.cyc_done = 1; tick();
        chk("b2b_second", 64'(bus.grant), 64'(5'b01000));
        chk("b2b_valid", 64'(bus.pa_valid), 64'(1));
        bus.req = '0; tick();
        chk("b2b_idle", 64'(bus.busy), 64'(0));
        bus.cyc_done = 0;

        // ERA freeze / release
        bus.req_kind = '0;
        bus.req_adr[0 +: PA_W] = 22'h001234; bus.req_adr[PA_W +: PA_W] = 22'h000777;
        bus.req = 4'b0001; tick();
        bus.req = 4'b0010; bus.err_in = 1; bus.cyc_done = 1; tick();
        chk("era_frozen", 64'(bus.era), 64'(22'h001234));
        chk("era_held", 64'(bus.era_held), 64'(1));
        bus.req = 4'b0001; bus.err_in = 0; bus.req_adr[0 +: PA_W] = 22'h0ABCDE; tick();
        chk("era_stays", 64'(bus.era), 64'(22'h001234));
        bus.req = '0; bus.cyc_done = 0; bus.err_in = 1; bus.era_unlock = 1; tick();
        chk("era_err_wins", 64'(bus.era_held), 64'(1));
        bus.err_in = 0; tick();
        chk("era_unlock", 64'(bus.era_held), 64'(0));
        bus.era_unlock = 0; bus.req = 4'b0010; bus.cyc_done = 1; tick();
        chk("era_reload", 64'(bus.era), 64'(22'h000777));
        bus.req = '0; tick();

        // Single-page sweep, cache finishing every cycle at once
        bus.sweep_start = 1; bus.sweep_all = 0; bus.sweep_page = 13'd5; tick();
        bus.sweep_start = 0;
        cnt = 0; dcnt = 0; first_pa = '0; last_pa = '0;
        for (int c = 0; c < 140; c++) begin
            tick();
            if (bus.pa_valid && bus.grant[NREQ]) begin
                if (cnt == 0) first_pa = bus.pa;
                last_pa = bus.pa;
                cnt++;
            end
            if (bus.sweep_done) dcnt++;
        end
        chk("sw1_grants", 64'(cnt), 64'(128));
        chk("sw1_done", 64'(dcnt), 64'(1));
        chk("sw1_first", 64'(first_pa), 64'({13'd5, 7'h7F, 2'b00}));
        chk("sw1_last", 64'(last_pa), 64'({13'd5, 7'h00, 2'b00}));

        // All-page sweep from page 1 with one external preemption mid-way
        bus.sweep_start = 1; bus.sweep_all = 1; bus.sweep_page = 13'd1; tick();
        bus.sweep_start = 0;
        bus.req_adr[2*PA_W +: PA_W] = 22'h2AAAAA;
        cnt = 0; dcnt = 0; ecnt = 0;
        for (int c = 0; c < 300; c++) begin
            bus.req = (c == 60) ? 4'b0100 : 4'b0000;
            tick();
            if (bus.pa_valid && bus.grant[NREQ]) begin
                chk("swa_seq", 64'(bus.pa), 64'(page_addr(1 - cnt / 128, 127 - cnt % 128)));
                cnt++;
            end
            if (bus.pa_valid && bus.grant[2]) ecnt++;
            if (bus.sweep_done) dcnt++;
        end
        bus.req = '0;
        chk("swa_grants", 64'(cnt), 64'(256));
        chk("swa_preempt", 64'(ecnt), 64'(1));
        chk("swa_done", 64'(dcnt), 64'(1));

        // Reset in the middle of a sweep
        bus.sweep_start = 1; bus.sweep_all = 0; bus.sweep_page = 13'd3; tick();
        bus.sweep_start = 0;
        for (int c = 0; c < 10; c++) tick();
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        chk("rst_grant", 64'(bus.grant), 64'(0));
        chk("rst_busy", 64'(bus.busy), 64'(0));
        chk("rst_sweep_busy", 64'(bus.sweep_busy), 64'(0));
        chk("rst_pa", 64'(bus.pa), 64'(0));
        check_all();
        #3 reset_n = 1'b1;
        dcnt = 0;
        for (int c = 0; c < 200; c++) begin
            tick();
            if (bus.sweep_done) dcnt++;
        end
        chk("rst_no_done", 64'(dcnt), 64'(0));

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            bus.req = ($urandom_range(0, 2) == 0) ? NREQ'($urandom) : '0;
            for (int j = 0; j < int'(NREQ); j++) bus.req_adr[j*PA_W +: PA_W] = PA_W'($urandom);
            bus.req_kind    = (2 * NREQ)'($urandom);
            bus.cyc_done    = ($urandom_range(0, 2) != 0);
            bus.ubr_ld      = ($urandom_range(0, 15) == 0);
            bus.ebr_ld      = ($urandom_range(0, 15) == 0);
            bus.base_d      = PG_W'($urandom);
            bus.sweep_start = ($urandom_range(0, 60) == 0);
            bus.sweep_all   = $urandom_range(0, 1) == 1;
            bus.sweep_page  = bus.sweep_all ? PG_W'($urandom_range(0, 1)) : PG_W'($urandom);
            bus.err_in      = ($urandom_range(0, 20) == 0);
            bus.era_unlock  = ($urandom_range(0, 10) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
